wand_string_arbiter: RTL
========================

Name: wand_string_arbiter

Overview:
- Shares the single doled SPI LED driver between two string pattern sources, for example the sine-wave generator and a diagnostic pattern source.
- Arbitration is string-granular. A requester that wins with a START element keeps the driver until its END element has been sent.
- Column pacing guarantees a minimum interval between string starts, so persistence-of-vision column spacing is fixed regardless of source.
- Sits between the pattern generators and doled, and drives doled's colour, type and start inputs directly.

Parameters:
- COLUMN_PERIOD, 50000: minimum dostring_clk cycles from one accepted START element to the next.
- PERIOD_W, 20: width of the column pacing counter.
- WDOG_CYCLES, 4096: watchdog timeout in cycles (used only with the optional feature).

Ports:
- dostring_clk  in  1  clock
- dostring_reset  in  1  reset
- req0_valid  in  1  requester 0 presents an element
- req0_type  in  2  element type: 0=START, 1=LED, 2=END
- req0_blue / req0_green / req0_red  in  8 each  requester 0 colour
- req0_ready  out  1  one-cycle pulse when requester 0's element is accepted
- req1_valid, req1_type, req1_blue, req1_green, req1_red, req1_ready  same as requester 0
- led_busy  in  1  doled_busy from the driver
- led_start  out  1  start pulse to the driver
- led_type  out  2  type to the driver
- led_blue / led_green / led_red  out  8 each  colour to the driver
- grant  out  2  0=none, 1=requester 0, 2=requester 1
- proto_err  out  1  one-cycle pulse when an element arrives out of protocol

Behaviour:
- Reset (dostring_reset, asynchronous, active-high; clock dostring_clk):
  - led_start=0, led_type=0, all colours 0.
  - reqN_ready=0, grant=0, proto_err=0.
  - last_winner=1, so requester 0 wins the first tie.
  - Pacing counter preset to COLUMN_PERIOD, so the first START is not delayed.
  - State IDLE.
- Pacing counter: increments each cycle and saturates at COLUMN_PERIOD. Cleared to 0 in the cycle a START element is accepted.
- IDLE:
  - A requester is eligible if it has valid=1, type=START, and the pacing counter equals COLUMN_PERIOD.
  - If both are eligible, the requester that is not last_winner wins (round-robin).
  - On a win, go to ACCEPT with grant set.
  - A valid element with type LED, END or 3 while IDLE: pulse that requester's ready, pulse proto_err, discard the element. If both requesters do this in the same cycle, both are acked and a single proto_err pulse is emitted.
- ACCEPT:
  - Taken from IDLE, or from WAIT_LOW when the granted requester has valid=1.
  - Latch the granted requester's type and colours into led_*.
  - Pulse the granted reqN_ready for exactly 1 cycle.
  - Go to START.
  - The non-granted requester's ready stays 0 throughout.
- START:
  - led_start=1 for exactly one cycle, then go to WAIT_HIGH.
  - led_* hold stable from ACCEPT until the driver returns to not-busy.
- WAIT_HIGH: wait for led_busy=1, then go to WAIT_LOW.
- WAIT_LOW: wait for led_busy=0.
  - If the last sent type was END: set last_winner to the granted requester, set grant=0, go to IDLE.
  - Otherwise stay holding the grant. When the granted requester next has valid=1, go to ACCEPT.
- Protocol errors while granted:
  - The granted requester presents START: it is sent as a normal element, proto_err pulses, and the grant is kept.
  - Type 3: sent as END, proto_err pulses.
- Latency: valid element to led_start is 2 cycles, to ready 1 cycle.
- Reset mid-string: everything returns to reset values immediately. The driver may be left mid-frame; recovery is the next START.

Optional Feature:
- Macro WAND_STRING_ARB_WATCHDOG_EN.
- With the macro: in WAIT_LOW while granted, a counter tracks consecutive cycles with granted valid=0. When it reaches WDOG_CYCLES, the arbiter itself loads an END element (led_type=2, colours 8'hff), pulses proto_err, and runs START, WAIT_HIGH and WAIT_LOW. It then releases the grant as for a normal END. The counter clears on any accepted element.
- Without the macro: the grant is held indefinitely, and WDOG_CYCLES is unused.

Test Plan:
- Both requesters present START at reset release with COLUMN_PERIOD=8: grant=1 first, req0_ready pulses, led_start follows 1 cycle later. Requester 1's START is accepted only after req0's END completes and the pacing counter reaches 8.
- Requester 0 sends START, 3 LED elements (blue=200, green=0, red=100), then END, with the driver model busy for 10 cycles each. The bench checks:
  - exactly 5 led_start pulses;
  - led_* stable across each busy window;
  - grant returns to 0 after the last busy falls.
- Requester 1 presents an LED element while IDLE: req1_ready and proto_err pulse for 1 cycle, led_start stays 0, grant stays 0.
- Back-to-back strings from requester 0 with COLUMN_PERIOD=100: the second START is accepted exactly 100 cycles after the first START acceptance, not earlier.
- With WAND_STRING_ARB_WATCHDOG_EN and WDOG_CYCLES=16: requester 0 sends START then goes silent. After 16 idle cycles an END is sent with colours 0xff and proto_err pulses. Requester 1 can then win.
- Assert reset during WAIT_HIGH: led_start=0, grant=0, ready=0 immediately. A subsequent START from requester 1 wins normally.

Source files
------------

// File: rtl/wand_string_arbiter.sv
// Two-source, string-granular arbiter feeding the doled SPI LED driver, with column pacing.
// Optional stalled-string watchdog enabled by defining WAND_STRING_ARB_WATCHDOG_EN.
module wand_string_arbiter #(
  parameter int unsigned COLUMN_PERIOD = 50000,
  parameter int unsigned PERIOD_W      = 20,
  parameter int unsigned WDOG_CYCLES   = 4096
) (
  input  logic       dostring_clk,
  input  logic       dostring_reset,
  input  logic       req0_valid,
  input  logic [1:0] req0_type,
  input  logic [7:0] req0_blue,
  input  logic [7:0] req0_green,
  input  logic [7:0] req0_red,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_type,
  input  logic [7:0] req1_blue,
  input  logic [7:0] req1_green,
  input  logic [7:0] req1_red,
  output logic       req1_ready,
  input  logic       led_busy,
  output logic       led_start,
  output logic [1:0] led_type,
  output logic [7:0] led_blue,
  output logic [7:0] led_green,
  output logic [7:0] led_red,
  output logic [1:0] grant,
  output logic       proto_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_START, S_WAIT_HIGH, S_WAIT_LOW
  } state_t;

  localparam logic [1:0] TYPE_START = 2'd0;
  localparam logic [1:0] TYPE_END   = 2'd2;
  localparam logic [1:0] TYPE_BAD   = 2'd3;
  localparam logic [PERIOD_W-1:0] PACE_MAX = PERIOD_W'(COLUMN_PERIOD);
  localparam logic [PERIOD_W-1:0] PACE_ONE = PERIOD_W'(1);

  if (COLUMN_PERIOD == 0 || (64'(COLUMN_PERIOD) >> PERIOD_W) != 0 || WDOG_CYCLES == 0)
  begin : g_param_check
    $error("wand_string_arbiter: COLUMN_PERIOD must be 1..2**PERIOD_W-1 and WDOG_CYCLES nonzero");
  end

`ifdef WAND_STRING_ARB_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt;
`endif

  state_t              state;
  logic [PERIOD_W-1:0] pace_cnt;
  logic                last_winner;
  logic                gidx;
  logic                pace_done, act0, act1, elig0, elig1, bad0, bad1, win1, win_any;
  logic                sel, sel_valid;
  logic [1:0]          sel_type;
  logic [7:0]          sel_blue, sel_green, sel_red;

  // A requester whose ready is high this cycle is still holding the element just taken.
  always_comb begin
    pace_done = (pace_cnt == PACE_MAX);
    act0      = req0_valid & ~req0_ready;
    act1      = req1_valid & ~req1_ready;
    elig0     = act0 & (req0_type == TYPE_START) & pace_done;
    elig1     = act1 & (req1_type == TYPE_START) & pace_done;
    bad0      = act0 & (req0_type != TYPE_START);
    bad1      = act1 & (req1_type != TYPE_START);
    win1      = elig1 & (~elig0 | ~last_winner);
    win_any   = elig0 | elig1;
    sel       = (state == S_IDLE) ? win1 : gidx;
    sel_valid = sel ? req1_valid : req0_valid;
    sel_type  = sel ? req1_type  : req0_type;
    sel_blue  = sel ? req1_blue  : req0_blue;
    sel_green = sel ? req1_green : req0_green;
    sel_red   = sel ? req1_red   : req0_red;
  end

  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      state       <= S_IDLE;
      pace_cnt    <= PACE_MAX;
      last_winner <= 1'b1;
      gidx        <= 1'b0;
      grant       <= '0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      proto_err   <= 1'b0;
      led_start   <= 1'b0;
      led_type    <= '0;
      led_blue    <= '0;
      led_green   <= '0;
      led_red     <= '0;
`ifdef WAND_STRING_ARB_WATCHDOG_EN
      wdog_cnt    <= '0;
`endif
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      proto_err  <= 1'b0;
      led_start  <= 1'b0;
      if (!pace_done) pace_cnt <= pace_cnt + PACE_ONE;
`ifdef WAND_STRING_ARB_WATCHDOG_EN
      if (state != S_WAIT_LOW) wdog_cnt <= '0;
`endif
      unique case (state)
        S_IDLE: begin
          if (win_any) begin
            state      <= S_ACCEPT;
            gidx       <= win1;
            grant      <= win1 ? 2'd2 : 2'd1;
            led_type   <= sel_type;
            led_blue   <= sel_blue;
            led_green  <= sel_green;
            led_red    <= sel_red;
            req0_ready <= ~win1;
            req1_ready <= win1;
            // The accepting cycle itself counts as cycle 0, so the register restarts at 1
            // and the next START becomes eligible exactly COLUMN_PERIOD cycles later.
            pace_cnt   <= PACE_ONE;
          end else if (bad0 | bad1) begin
            req0_ready <= bad0;
            req1_ready <= bad1;
            proto_err  <= 1'b1;
          end
        end
        S_ACCEPT: begin
          led_start <= 1'b1;
          state     <= S_START;
        end
        S_START: state <= S_WAIT_HIGH;
        S_WAIT_HIGH: if (led_busy) state <= S_WAIT_LOW;
        S_WAIT_LOW: begin
          if (!led_busy) begin
            if (led_type == TYPE_END) begin
              last_winner <= gidx;
              grant       <= '0;
              state       <= S_IDLE;
            end else if (sel_valid) begin
              state      <= S_ACCEPT;
              led_type   <= (sel_type == TYPE_BAD) ? TYPE_END : sel_type;
              led_blue   <= sel_blue;
              led_green  <= sel_green;
              led_red    <= sel_red;
              req0_ready <= ~gidx;
              req1_ready <= gidx;
              proto_err  <= (sel_type == TYPE_START) | (sel_type == TYPE_BAD);
`ifdef WAND_STRING_ARB_WATCHDOG_EN
              wdog_cnt   <= '0;
            end else if (wdog_cnt == WDOG_LAST) begin
              // Close the stalled string ourselves; no requester is acked.
              state      <= S_START;
              led_start  <= 1'b1;
              led_type   <= TYPE_END;
              led_blue   <= '1;
              led_green  <= '1;
              led_red    <= '1;
              proto_err  <= 1'b1;
              wdog_cnt   <= '0;
            end else begin
              wdog_cnt   <= wdog_cnt + 1'b1;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
